// File: rtl/sdp_bram_pipe_pkg.sv
// ============================================================================
// Module   : sdp_bram_pipe_pkg
// Brief    : Shared helpers for the sdp_bram_pipe RAM: depth calculation,
//            legal read-latency bounds and the sweep/run state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdp_bram_pipe_pkg;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   // Controller states: zeroing sweep after reset, then normal operation
   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   // Number of words addressed by an addr_w-bit address
   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sdp_bram_pipe_core.sv
// ============================================================================
// Module   : sdp_bram_pipe_core
// Brief    : Bare inferable simple-dual-port array with a registered read.
//            Same-address write/read returns the old word; write-first
//            behaviour is provided by the wrapper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdp_bram_pipe_core
   import sdp_bram_pipe_pkg::*;
#(
   parameter int WIDTH  = 75,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   localparam int DEPTH = depth_of(ADDR_W);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Write port: one full word per enabled cycle
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read port: registered array output, holds when no read is issued
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/sdp_bram_pipe.sv
// ============================================================================
// Module   : sdp_bram_pipe
// Brief    : Parametrised single-clock simple-dual-port block RAM with a
//            read request/valid pipeline (latency 1 or 2), write-first
//            collision forwarding and a post-reset zeroing sweep.
//            Optional macro SDP_BRAM_PIPE_PARITY_EN adds an even-parity bit
//            per word and a perr output aligned with rd_valid.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdp_bram_pipe
   import sdp_bram_pipe_pkg::*;
#(
   parameter int DATA_W     = 75,
   parameter int ADDR_W     = 10,
   parameter int RD_LAT     = 1,
   parameter int INIT_CLEAR = 1
) (
   input  logic              clk,
   input  logic              rst,
   output logic              init_busy,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data
`ifdef SDP_BRAM_PIPE_PARITY_EN
   ,
   output logic              perr
`endif
);

`ifdef SDP_BRAM_PIPE_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif
   localparam int                DEPTH    = depth_of(ADDR_W);
   localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

   // Stored word for a given data value (parity bit on top when enabled)
   function automatic logic [MEM_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef SDP_BRAM_PIPE_PARITY_EN
      return {^d, d};
`else
      return d;
`endif
   endfunction

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   logic              rd_fire, wr_fire;
   logic [MEM_W-1:0]  wr_word;
   logic              core_we;
   logic [ADDR_W-1:0] core_waddr;
   logic [MEM_W-1:0]  core_wdata;
   logic [MEM_W-1:0]  core_rdata;

   logic              v1_q, v1_d;
   logic              fwd_sel_q, fwd_sel_d;
   logic [MEM_W-1:0]  fwd_word_q, fwd_word_d;
   logic [MEM_W-1:0]  s1_word;

   logic              out_valid;
   logic [MEM_W-1:0]  out_word;

   // Sweep sequencing: one address per cycle, leave CLEAR after the last word
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == CLEAR) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CNT_LAST) begin
            state_d = RUN;
         end
      end
   end

   // Controller registers; the sweep restarts from address 0 on every reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= (INIT_CLEAR != 0) ? CLEAR : RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign init_busy = (state_q == CLEAR);

   // User accesses only take effect in RUN and outside reset
   assign rd_fire = !rst && !init_busy && rd_en;
   assign wr_fire = !rst && !init_busy && wr_en;
   assign wr_word = encode(wr_data);

   // The sweep owns the write port while busy
   assign core_we    = !rst && (init_busy || wr_fire);
   assign core_waddr = init_busy ? cnt_q : wr_addr;
   assign core_wdata = init_busy ? '0 : wr_word;

   sdp_bram_pipe_core #(
      .WIDTH  (MEM_W),
      .ADDR_W (ADDR_W)
   ) u_core (
      .clk     (clk),
      .wr_en   (core_we),
      .wr_addr (core_waddr),
      .wr_data (core_wdata),
      .rd_en   (rd_fire),
      .rd_addr (rd_addr),
      .rd_data (core_rdata)
   );

   // First read stage: valid flag and write-first bypass, both captured with the read
   always_comb begin
      v1_d       = rd_fire;
      fwd_sel_d  = fwd_sel_q;
      fwd_word_d = fwd_word_q;
      if (rd_fire) begin
         fwd_sel_d  = wr_fire && (wr_addr == rd_addr);
         fwd_word_d = wr_word;
      end
   end

   // Reset selects the bypass with a zero word so rd_data reads 0 until the
   // first real read, without needing a reset on the array output register
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q       <= 1'b0;
         fwd_sel_q  <= 1'b1;
         fwd_word_q <= '0;
      end else begin
         v1_q       <= v1_d;
         fwd_sel_q  <= fwd_sel_d;
         fwd_word_q <= fwd_word_d;
      end
   end

   assign s1_word = fwd_sel_q ? fwd_word_q : core_rdata;

   generate
      if (RD_LAT == RD_LAT_MIN) begin : g_lat1
         assign out_valid = v1_q;
         assign out_word  = s1_word;
      end else if (RD_LAT == RD_LAT_MAX) begin : g_lat2
         logic             v2_q, v2_d;
         logic [MEM_W-1:0] s2_q, s2_d;

         // Second stage re-registers the first-stage word only when it is valid
         always_comb begin
            v2_d = v1_q;
            s2_d = s2_q;
            if (v1_q) begin
               s2_d = s1_word;
            end
         end

         // Output stage registers
         always_ff @(posedge clk) begin
            if (rst) begin
               v2_q <= 1'b0;
               s2_q <= '0;
            end else begin
               v2_q <= v2_d;
               s2_q <= s2_d;
            end
         end

         assign out_valid = v2_q;
         assign out_word  = s2_q;
      end else begin : g_lat_illegal
         $error("sdp_bram_pipe: RD_LAT must be 1 or 2");
      end
   endgenerate

   assign rd_valid = out_valid;
   assign rd_data  = out_word[DATA_W-1:0];

`ifdef SDP_BRAM_PIPE_PARITY_EN
   // Stored even parity makes the XOR of the whole word zero when intact
   assign perr = out_valid && (^out_word);
`endif

endmodule

`default_nettype wire

// File: tb/tb_sdp_bram_pipe.sv
// ============================================================================
// Module   : tb_sdp_bram_pipe
// Brief    : Self-checking bench for sdp_bram_pipe. Two instances (read
//            latency 1 and 2) share one stimulus stream and are compared
//            against a word-array model with a queue of pending reads.
//            Parity checks are active when SDP_BRAM_PIPE_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sdp_bram_pipe;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [AW-1:0] rd_addr = '0;
   logic [DW-1:0] wr_data = '0;

   logic          busy1, busy2, v1, v2;
   logic [DW-1:0] d1, d2;
`ifdef SDP_BRAM_PIPE_PARITY_EN
   logic          perr1, perr2;
`endif

   always #5 clk = ~clk;

   sdp_bram_pipe #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .INIT_CLEAR(1)) u_dut1 (
      .clk(clk), .rst(rst), .init_busy(busy1),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(v1), .rd_data(d1)
`ifdef SDP_BRAM_PIPE_PARITY_EN
      , .perr(perr1)
`endif
   );

   sdp_bram_pipe #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .INIT_CLEAR(1)) u_dut2 (
      .clk(clk), .rst(rst), .init_busy(busy2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(v2), .rd_data(d2)
`ifdef SDP_BRAM_PIPE_PARITY_EN
      , .perr(perr2)
`endif
   );

   // ---------------- reference model ----------------
   typedef struct {
      int            due;
      logic [DW-1:0] d;
      bit            bad;
   } rd_t;

   rd_t           q1[$];
   rd_t           q2[$];
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_bad [DEPTH];
   int            busy_left = 0;
   int            edge_n = 0;
   logic [DW-1:0] last1 = '0;
   logic [DW-1:0] last2 = '0;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
      end
   endtask

   // One clock cycle: drive inputs, advance the model at the edge, check both DUTs
   task automatic step(input logic r, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
      rd_t e;
      rd_t h;
      bit  ev;
      rst = r; wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
      @(posedge clk);
      edge_n++;
      if (r) begin
         busy_left = DEPTH;
         q1.delete();
         q2.delete();
         last1 = '0;
         last2 = '0;
      end else if (busy_left > 0) begin
         busy_left--;
         if (busy_left == 0) begin
            foreach (m_mem[i]) begin
               m_mem[i] = '0;
               m_bad[i] = 1'b0;
            end
         end
      end else begin
         if (re) begin
            e.d   = (we && wa == ra) ? wd : m_mem[ra];
            e.bad = (we && wa == ra) ? 1'b0 : m_bad[ra];
            e.due = edge_n;
            q1.push_back(e);
            e.due = edge_n + 1;
            q2.push_back(e);
         end
         if (we) begin
            m_mem[wa] = wd;
            m_bad[wa] = 1'b0;
         end
      end
      #1;
      check("lat1 init_busy", 32'(busy1), 32'(busy_left != 0));
      check("lat2 init_busy", 32'(busy2), 32'(busy_left != 0));

      h.bad = 1'b0;
      ev = (q1.size() > 0) && (q1[0].due == edge_n);
      if (ev) begin h = q1.pop_front(); last1 = h.d; end
      check("lat1 rd_valid", 32'(v1), 32'(ev));
      check("lat1 rd_data", 32'(d1), 32'(last1));
`ifdef SDP_BRAM_PIPE_PARITY_EN
      check("lat1 perr", 32'(perr1), 32'(ev && h.bad));
`endif

      h.bad = 1'b0;
      ev = (q2.size() > 0) && (q2[0].due == edge_n);
      if (ev) begin h = q2.pop_front(); last2 = h.d; end
      check("lat2 rd_valid", 32'(v2), 32'(ev));
      check("lat2 rd_data", 32'(d2), 32'(last2));
`ifdef SDP_BRAM_PIPE_PARITY_EN
      check("lat2 perr", 32'(perr2), 32'(ev && h.bad));
`endif
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0);
   endtask

   initial begin
      // Reset for two cycles, then hold a read of addr 5 and a write of 0xFF
      // to addr 15 through the sweep; neither may take effect while busy
      step(1'b1, 1'b0, '0, '0, 1'b0, '0);
      step(1'b1, 1'b0, '0, '0, 1'b0, '0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 4'd15, 8'hFF, 1'b1, 4'd5);
      step(1'b0, 1'b0, '0, '0, 1'b1, 4'd5);
      step(1'b0, 1'b0, '0, '0, 1'b1, 4'd5);
      step(1'b0, 1'b0, '0, '0, 1'b1, 4'd15);
      idle(3);

      // Reset in the middle of the sweep restarts it from scratch
      step(1'b1, 1'b0, '0, '0, 1'b0, '0);
      idle(7);
      step(1'b1, 1'b0, '0, '0, 1'b0, '0);
      idle(DEPTH);
      for (int a = 0; a < DEPTH; a++) step(1'b0, 1'b0, '0, '0, 1'b1, AW'(a));
      idle(3);

      // Latency and back-to-back reads, then hold of the last word
      step(1'b0, 1'b1, 4'd2, 8'h3C, 1'b0, '0);
      step(1'b0, 1'b1, 4'd3, 8'hA5, 1'b0, '0);
      step(1'b0, 1'b0, '0, '0, 1'b1, 4'd2);
      step(1'b0, 1'b0, '0, '0, 1'b1, 4'd3);
      idle(4);

      // Write-first collision, followed by a same-address write next cycle
      step(1'b0, 1'b1, 4'd9, 8'h11, 1'b0, '0);
      step(1'b0, 1'b1, 4'd9, 8'h77, 1'b1, 4'd9);
      step(1'b0, 1'b1, 4'd9, 8'h55, 1'b0, '0);
      idle(3);
      step(1'b0, 1'b0, '0, '0, 1'b1, 4'd9);
      idle(3);

      // Randomized traffic with small address range to provoke collisions
      for (int i = 0; i < 400; i++) begin
         logic r;
         r = ($urandom_range(0, 99) < 2);
         step(r, r ? 1'b0 : 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
              DW'($urandom), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)));
      end
      idle(DEPTH + 3);

`ifdef SDP_BRAM_PIPE_PARITY_EN
      // Clean word reads with perr=0; a flipped stored bit must raise perr
      step(1'b0, 1'b1, 4'd4, 8'h0F, 1'b0, '0);
      step(1'b0, 1'b0, '0, '0, 1'b1, 4'd4);
      idle(3);
      u_dut1.u_core.mem[4] = u_dut1.u_core.mem[4] ^ 9'h001;
      u_dut2.u_core.mem[4] = u_dut2.u_core.mem[4] ^ 9'h001;
      m_mem[4] = m_mem[4] ^ 8'h01;
      m_bad[4] = 1'b1;
      step(1'b0, 1'b0, '0, '0, 1'b1, 4'd4);
      idle(3);
      // A forwarded collision on the damaged word carries fresh parity
      step(1'b0, 1'b1, 4'd4, 8'h0F, 1'b1, 4'd4);
      step(1'b0, 1'b0, '0, '0, 1'b1, 4'd4);
      idle(3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sdp_bram_pipe.md
Name: sdp_bram_pipe

Overview:
Parametrised single-clock simple-dual-port block RAM. Successor to the fixed 1024x75 LPM buffer. Adds generic width/depth, a read request/valid pipeline with selectable latency (1 or 2), write-first collision forwarding, and a post-reset clear sweep. It serves as the shared coefficient/partial-product store for the accelerator datapath.

Parameters:
DATA_W, 75, word width in bits
ADDR_W, 10, address width; DEPTH = 2**ADDR_W words
RD_LAT, 1, read latency in cycles; legal values 1 or 2; any other value is a synthesis error
INIT_CLEAR, 1, 1 = zero every word after reset; 0 = no sweep, array contents undefined after reset

Ports:
clk  in  1  single clock for both ports, rising edge
rst  in  1  reset; synchronous, active-high
init_busy  out  1  high while the clear sweep runs; user accesses are dropped while high
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_en  in  1  read request
rd_addr  in  ADDR_W  read address
rd_valid  out  1  rd_data is valid this cycle
rd_data  out  DATA_W  read data; holds its last value when rd_valid is low

Behaviour:
- Reset (rst=1 at a clk edge):
  - rd_valid=0, rd_data=0, all pipeline valids=0.
  - Clear counter=0.
  - State = CLEAR if INIT_CLEAR=1, else RUN.
  - init_busy = INIT_CLEAR.
  - The array itself is never reset.
- FSM states: CLEAR and RUN.
  - CLEAR: each cycle with rst=0, write 0 to address cnt, then cnt++.
  - When cnt = DEPTH-1 is written, go to RUN. init_busy drops at that same edge.
  - Result: init_busy is high for exactly DEPTH cycles after rst deasserts.
  - RUN: normal operation; no exit except rst.
- Reset mid-sweep: the sweep restarts from address 0 and takes the full DEPTH cycles again.
- Accesses during CLEAR:
  - wr_en and rd_en are ignored: no write, no rd_valid.
  - The requester must wait for init_busy=0. There is no backpressure and no queuing.
- Write: when wr_en=1 in RUN, mem[wr_addr] <= wr_data at that edge. No write enable per byte.
- Read, RD_LAT=1:
  - rd_en=1 at edge t captures mem[rd_addr] into rd_data.
  - rd_valid=1 during cycle t+1.
- Read, RD_LAT=2:
  - Array output is registered at edge t, then re-registered at edge t+1.
  - rd_valid=1 during cycle t+2.
  - Data is sampled at edge t; a write at t+1 to the same address does not change it.
- Reads are fully pipelined: one request per cycle, back-to-back, no bubbles.
- rd_valid for a request depends only on rd_en in RUN. No other condition cancels it.
- Collision (rd_en and wr_en in the same cycle, rd_addr = wr_addr, RUN): write-first. The read returns the new wr_data.
- Different-address simultaneous read and write: both complete independently.
- Address wrap: addresses are ADDR_W bits wide. The clear counter covers 0..DEPTH-1 exactly; no out-of-range access is possible.

Optional Feature:
- Macro: SDP_BRAM_PIPE_PARITY_EN.
- When defined:
  - The array is DATA_W+1 bits wide; the extra bit is even parity of the data bits, computed on write.
  - The clear sweep writes parity 0.
  - New output perr (1 bit) is aligned with rd_valid. It is 1 when the stored parity mismatches the recomputed parity of the read word.
  - perr is reset to 0 and is 0 whenever rd_valid=0.
  - Collision forwarding forwards the computed parity, so perr=0 on forwarded data.
  - A bench-only hidden-state force on a stored bit must produce perr=1.
- When not defined: no perr port, no extra bit; behaviour is otherwise identical.

Decomposition:
- Shared package: localparam helpers only, namely DEPTH = 1<<ADDR_W, RD_LAT_MIN=1, RD_LAT_MAX=2, and the state encoding (CLEAR=1'b0, RUN=1'b1).
- One natural sub-module: sdp_bram_pipe_core. It holds the bare inferable array: registered read, write-first handled outside. The top keeps the FSM, clear counter, forwarding mux, latency pipeline and parity.

Test Plan:
- Reset and clear (DATA_W=8, ADDR_W=4, INIT_CLEAR=1): pulse rst for 2 cycles, then hold rd_en=1 on address 5 from release. Expect init_busy high for exactly 16 cycles and no rd_valid during that time. The first rd_valid comes 1 cycle after init_busy falls, with rd_data=0.
- Reset mid-sweep: assert rst at sweep cycle 7 of 16. Expect init_busy to stay high 16 full cycles after the second release. Addresses 0..15 all read back 0.
- Latency (RD_LAT=1 and RD_LAT=2): write 0x3C to addr 2, then 0xA5 to addr 3. Issue back-to-back reads of 2 then 3. Expect rd_valid on consecutive cycles at t+1 and t+2 (or t+2 and t+3), with data 0x3C then 0xA5. rd_data holds 0xA5 afterwards while rd_valid=0.
- Collision: mem[9]=0x11; in the same cycle write 0x77 to addr 9 and read addr 9. Expect rd_data=0x77. For RD_LAT=2, a write of 0x55 to addr 9 on the next cycle still leaves this read returning 0x77.
- Ignored accesses: during the sweep, write 0xFF to addr 15. After the sweep, reading addr 15 returns 0x00.
- Parity (SDP_BRAM_PIPE_PARITY_EN defined): write 0x0F to addr 4 and read it: perr=0. Force-flip data bit 0 of mem[4] and read again: perr=1 together with rd_valid.
